// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - machine-mode trap entry / mret sequencer with flush handshake
module trap_ctrl #(
  parameter int NUM_EXT_IRQ = 4,
  parameter int ID_W        = 2
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   exc_valid,
  input  logic [3:0]             exc_cause,
  input  logic [31:0]            exc_pc,
  input  logic                   mret_valid,
  input  logic [31:0]            retire_pc,
  input  logic                   irq_timer,
  input  logic                   irq_soft,
  input  logic [NUM_EXT_IRQ-1:0] irq_ext,
  input  logic                   mstatus_mie,
  input  logic [31:0]            mie,
  input  logic [31:0]            mtvec,
  input  logic [31:0]            mepc,
  output logic                   flush_req,
  input  logic                   flush_ack,
  output logic                   trap_we,
  output logic [31:0]            trap_mepc,
  output logic [31:0]            trap_mcause,
  output logic [ID_W-1:0]        trap_irq_id,
  output logic                   mret_commit,
  output logic                   redirect_valid,
  output logic [31:0]            redirect_pc,
  output logic [31:0]            mip,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    COMMIT   = 2'd2,
    REDIRECT = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              mret_q, mret_d;
  logic              intr_q, intr_d;
  logic [3:0]        code_q, code_d;
  logic [31:0]       pc_q, pc_d;
  logic [ID_W-1:0]   id_q, id_d;

  logic              ext_pend;
  logic              ext_elig;
  logic              sw_elig;
  logic              tm_elig;
  logic [ID_W-1:0]   ext_id;
  logic [31:0]       trap_base;
  logic [31:0]       trap_target;

  // Only MSIE/MTIE/MEIE matter here; the remaining mie bits are intentionally ignored.
  logic              unused_mie;
  assign unused_mie = ^{mie[31:12], mie[10:8], mie[6:4], mie[2:0]};

  assign ext_pend = |irq_ext;
  assign ext_elig = mstatus_mie & mie[11] & ext_pend;
  assign sw_elig  = mstatus_mie & mie[3]  & irq_soft;
  assign tm_elig  = mstatus_mie & mie[7]  & irq_timer;

  assign mip  = {20'b0, ext_pend, 3'b0, irq_timer, 3'b0, irq_soft, 3'b0};
  assign busy = (state_q != IDLE);

  // Lowest-index asserted external line wins; scan from the top so low indices overwrite.
  always_comb begin
    ext_id = '0;
    for (int i = NUM_EXT_IRQ - 1; i >= 0; i--) begin
      if (irq_ext[i]) ext_id = ID_W'(i);
    end
  end

  // Vectored mode only applies to interrupts; modes 2 and 3 fall back to direct.
  always_comb begin
    trap_base = {mtvec[31:2], 2'b00};
    if (mtvec[1:0] == 2'b01 && intr_q) begin
      trap_target = trap_base + {26'b0, code_q, 2'b00};
    end else begin
      trap_target = trap_base;
    end
  end

  // State and latched-event registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      mret_q  <= 1'b0;
      intr_q  <= 1'b0;
      code_q  <= 4'd0;
      pc_q    <= 32'd0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      mret_q  <= mret_d;
      intr_q  <= intr_d;
      code_q  <= code_d;
      pc_q    <= pc_d;
      id_q    <= id_d;
    end
  end

  // Next-state, event arbitration in IDLE and output decode.
  always_comb begin
    state_d        = state_q;
    mret_d         = mret_q;
    intr_d         = intr_q;
    code_d         = code_q;
    pc_d           = pc_q;
    id_d           = id_q;
    flush_req      = 1'b0;
    trap_we        = 1'b0;
    trap_mepc      = 32'd0;
    trap_mcause    = 32'd0;
    trap_irq_id    = '0;
    mret_commit    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;

    case (state_q)
      IDLE: begin
        if (exc_valid) begin
          state_d = FLUSH;
          mret_d  = 1'b0;
          intr_d  = 1'b0;
          code_d  = exc_cause;
          pc_d    = exc_pc;
          id_d    = '0;
        end else if (ext_elig) begin
          state_d = FLUSH;
          mret_d  = 1'b0;
          intr_d  = 1'b1;
          code_d  = 4'd11;
          pc_d    = retire_pc;
          id_d    = ext_id;
        end else if (sw_elig) begin
          state_d = FLUSH;
          mret_d  = 1'b0;
          intr_d  = 1'b1;
          code_d  = 4'd3;
          pc_d    = retire_pc;
          id_d    = '0;
        end else if (tm_elig) begin
          state_d = FLUSH;
          mret_d  = 1'b0;
          intr_d  = 1'b1;
          code_d  = 4'd7;
          pc_d    = retire_pc;
          id_d    = '0;
        end else if (mret_valid) begin
          state_d = FLUSH;
          mret_d  = 1'b1;
          intr_d  = 1'b0;
          code_d  = 4'd0;
          pc_d    = 32'd0;
          id_d    = '0;
        end
      end
      FLUSH: begin
        flush_req = 1'b1;
        if (flush_ack) begin
          state_d = mret_q ? REDIRECT : COMMIT;
        end
      end
      COMMIT: begin
        trap_we     = 1'b1;
        trap_mepc   = pc_q;
        trap_mcause = {intr_q, 27'b0, code_q};
        trap_irq_id = (intr_q && code_q == 4'd11) ? id_q : '0;
        state_d     = REDIRECT;
      end
      REDIRECT: begin
        redirect_valid = 1'b1;
        mret_commit    = mret_q;
        redirect_pc    = mret_q ? mepc : trap_target;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - directed self-checking bench for trap_ctrl
module tb_trap_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        exc_valid;
  logic [3:0]  exc_cause;
  logic [31:0] exc_pc;
  logic        mret_valid;
  logic [31:0] retire_pc;
  logic        irq_timer;
  logic        irq_soft;
  logic [3:0]  irq_ext;
  logic        mstatus_mie;
  logic [31:0] mie;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic        flush_req;
  logic        flush_ack;
  logic        trap_we;
  logic [31:0] trap_mepc;
  logic [31:0] trap_mcause;
  logic [1:0]  trap_irq_id;
  logic        mret_commit;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] mip;
  logic        busy;

  int total = 0;
  int bad   = 0;

  int          flush_cnt, we_cnt, rd_cnt, mc_cnt, we_idx, rd_idx;
  logic [31:0] got_mcause, got_mepc, got_id, got_rpc;
  logic        mret_at_rd;

  trap_ctrl #(.NUM_EXT_IRQ(4), .ID_W(2)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .exc_valid      (exc_valid),
    .exc_cause      (exc_cause),
    .exc_pc         (exc_pc),
    .mret_valid     (mret_valid),
    .retire_pc      (retire_pc),
    .irq_timer      (irq_timer),
    .irq_soft       (irq_soft),
    .irq_ext        (irq_ext),
    .mstatus_mie    (mstatus_mie),
    .mie            (mie),
    .mtvec          (mtvec),
    .mepc           (mepc),
    .flush_req      (flush_req),
    .flush_ack      (flush_ack),
    .trap_we        (trap_we),
    .trap_mepc      (trap_mepc),
    .trap_mcause    (trap_mcause),
    .trap_irq_id    (trap_irq_id),
    .mret_commit    (mret_commit),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mip            (mip),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_events();
    exc_valid  = 1'b0;
    mret_valid = 1'b0;
    irq_timer  = 1'b0;
    irq_soft   = 1'b0;
    irq_ext    = 4'b0;
  endtask

  // Walks one accepted event to its redirect, acking the flush after ack_dly FLUSH cycles.
  // Index 1 is the first negedge after the accepting posedge.
  task automatic run_seq(input int ack_dly);
    int  fcnt;
    bit  done;
    fcnt = 0; done = 0;
    we_cnt = 0; rd_cnt = 0; mc_cnt = 0; we_idx = 0; rd_idx = 0;
    got_mcause = '0; got_mepc = '0; got_id = '0; got_rpc = '0; mret_at_rd = 1'b0;
    for (int i = 1; i <= 40 && !done; i++) begin
      @(negedge clock);
      if (trap_we) begin
        we_cnt++;
        we_idx     = i;
        got_mcause = trap_mcause;
        got_mepc   = trap_mepc;
        got_id     = 32'(trap_irq_id);
      end
      if (mret_commit) mc_cnt++;
      if (redirect_valid) begin
        rd_cnt++;
        rd_idx     = i;
        got_rpc    = redirect_pc;
        mret_at_rd = mret_commit;
        clear_events();
        done = 1;
      end
      if (flush_req) begin
        fcnt++;
        flush_ack = (fcnt >= ack_dly);
      end else begin
        flush_ack = 1'b0;
      end
    end
    check("seq_done", 32'(done), 32'd1);
    flush_cnt = fcnt;
    @(negedge clock);
    flush_ack = 1'b0;
    check("idle_after", 32'(busy), 32'd0);
  endtask

  initial begin
    int cnt;
    reset_n     = 1'b0;
    clear_events();
    exc_cause   = 4'd0;
    exc_pc      = 32'd0;
    retire_pc   = 32'd0;
    mstatus_mie = 1'b0;
    mie         = 32'd0;
    mtvec       = 32'd0;
    mepc        = 32'd0;
    flush_ack   = 1'b0;
    irq_timer   = 1'b1;

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_mip", mip, 32'h80);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_flush", 32'(flush_req), 32'd0);
    check("rst_we", 32'(trap_we), 32'd0);
    check("rst_redir", 32'(redirect_valid), 32'd0);
    check("rst_rpc", redirect_pc, 32'd0);
    check("rst_mcause", trap_mcause, 32'd0);

    // Globally disabled timer must not trap
    mie = 32'h80;
    reset_n = 1'b1;
    cnt = 0;
    repeat (5) begin
      @(negedge clock);
      if (flush_req) cnt++;
    end
    check("mie0_noflush", 32'(cnt), 32'd0);
    clear_events();

    // Illegal instruction, ack after 3 flush cycles, vectored mtvec ignored for exceptions
    mtvec = 32'h8000_0001;
    exc_valid = 1'b1; exc_cause = 4'd2; exc_pc = 32'h100;
    run_seq(3);
    check("ill_flushcnt", 32'(flush_cnt), 32'd3);
    check("ill_wecnt", 32'(we_cnt), 32'd1);
    check("ill_mcause", got_mcause, 32'h2);
    check("ill_mepc", got_mepc, 32'h100);
    check("ill_rpc", got_rpc, 32'h8000_0000);
    check("ill_rd_after_we", 32'(rd_idx - we_idx), 32'd1);

    // Timer interrupt, immediate ack
    @(negedge clock);
    mstatus_mie = 1'b1; mie = 32'h80; retire_pc = 32'h204; irq_timer = 1'b1;
    run_seq(1);
    check("tmr_flushcnt", 32'(flush_cnt), 32'd1);
    check("tmr_we_idx", 32'(we_idx), 32'd2);
    check("tmr_rd_idx", 32'(rd_idx), 32'd3);
    check("tmr_mcause", got_mcause, 32'h8000_0007);
    check("tmr_mepc", got_mepc, 32'h204);
    check("tmr_rpc", got_rpc, 32'h8000_001C);

    // External beats timer; lowest asserted line is 1
    @(negedge clock);
    mie = 32'h880; retire_pc = 32'h210; irq_timer = 1'b1; irq_ext = 4'b0110;
    run_seq(1);
    check("ext_mcause", got_mcause, 32'h8000_000B);
    check("ext_id", got_id, 32'd1);
    check("ext_mepc", got_mepc, 32'h210);
    check("ext_rpc", got_rpc, 32'h8000_002C);

    // Same lines but MEIE off: timer wins
    @(negedge clock);
    mie = 32'h080; irq_timer = 1'b1; irq_ext = 4'b0110;
    run_seq(1);
    check("extoff_mcause", got_mcause, 32'h8000_0007);
    check("extoff_id", got_id, 32'd0);
    check("extoff_rpc", got_rpc, 32'h8000_001C);

    // Software interrupt with mtvec mode 3 treated as direct
    @(negedge clock);
    mtvec = 32'h8000_0003; mie = 32'h8; retire_pc = 32'h220; irq_soft = 1'b1;
    run_seq(2);
    check("sw_flushcnt", 32'(flush_cnt), 32'd2);
    check("sw_mcause", got_mcause, 32'h8000_0003);
    check("sw_rpc", got_rpc, 32'h8000_0000);
    mtvec = 32'h8000_0001;

    // Exception beats timer and mret
    @(negedge clock);
    mie = 32'h80; irq_timer = 1'b1; mret_valid = 1'b1;
    exc_valid = 1'b1; exc_cause = 4'd3; exc_pc = 32'h40;
    run_seq(1);
    check("exc_mcause", got_mcause, 32'h3);
    check("exc_mepc", got_mepc, 32'h40);
    check("exc_no_mret", 32'(mc_cnt), 32'd0);
    check("exc_rpc", got_rpc, 32'h8000_0000);

    // mret alone
    @(negedge clock);
    mepc = 32'h300; mret_valid = 1'b1;
    run_seq(1);
    check("mret_flushcnt", 32'(flush_cnt), 32'd1);
    check("mret_no_we", 32'(we_cnt), 32'd0);
    check("mret_commit_w_rd", 32'(mret_at_rd), 32'd1);
    check("mret_commit_cnt", 32'(mc_cnt), 32'd1);
    check("mret_rpc", got_rpc, 32'h300);

    // Reset abort during FLUSH
    @(negedge clock);
    exc_valid = 1'b1; exc_cause = 4'd11; exc_pc = 32'h50;
    cnt = 0;
    while (!flush_req && cnt < 10) begin
      @(negedge clock);
      cnt++;
    end
    check("abort_in_flush", 32'(flush_req), 32'd1);
    reset_n = 1'b0;
    #1;
    check("abort_flush0", 32'(flush_req), 32'd0);
    check("abort_busy0", 32'(busy), 32'd0);
    check("abort_we0", 32'(trap_we), 32'd0);
    check("abort_rd0", 32'(redirect_valid), 32'd0);
    clear_events();
    @(negedge clock);
    reset_n = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(negedge clock);
      if (trap_we || redirect_valid || flush_req) cnt++;
    end
    check("abort_quiet", 32'(cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
